// File: rtl/cla_pkg.sv
// Shared constants and lookahead helpers for the pipelined CLA adder.
package cla_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int GROUP_DEF = 4;
  // Widest group the helper below accepts; callers zero-extend narrower groups.
  localparam int GMAX      = 16;

  function automatic int ng_of(input int width, input int group);
    return width / group;
  endfunction

  // Returns {P, G} of the low n bits, with G in OR-of-ANDs form.
  function automatic logic [1:0] group_pg(input logic [GMAX-1:0] p,
                                          input logic [GMAX-1:0] g,
                                          input int n);
    logic pr;
    logic gr;
    pr = 1'b1;
    gr = 1'b0;
    for (int k = GMAX - 1; k >= 0; k--) begin
      if (k < n) begin
        gr = gr | (g[k] & pr);
        pr = pr & p[k];
      end
    end
    return {pr, gr};
  endfunction

endpackage

// File: rtl/cla_pipe_adder_if.sv
// Operand/result handshake bundle for cla_pipe_adder.
interface cla_pipe_adder_if #(parameter int WIDTH = 32);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic             pg;
  logic             gg;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, s, cout, ovf, zero, pg, gg
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, s, cout, ovf, zero, pg, gg
  );

endinterface

// File: rtl/cla_group.sv
// GROUP-bit carry-lookahead unit: sum from an incoming carry plus group P/G.
module cla_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] s,
  output logic             p,
  output logic             g
);

  logic [GROUP-1:0] pb;
  logic [GROUP-1:0] gb;
  logic [GROUP-1:0] c;
  logic             acc;
  logic             pr;

  always_comb begin
    pb  = a ^ b;
    gb  = a & b;
    c   = '0;
    acc = 1'b0;
    pr  = 1'b1;
    // Each internal carry is a flat sum of products, not a ripple.
    for (int k = 0; k < GROUP; k++) begin
      acc = 1'b0;
      pr  = 1'b1;
      for (int j = k - 1; j >= 0; j--) begin
        acc = acc | (gb[j] & pr);
        pr  = pr & pb[j];
      end
      c[k] = acc | (pr & cin);
    end
    s = pb ^ c;
    p = &pb;
    acc = 1'b0;
    pr  = 1'b1;
    for (int j = GROUP - 1; j >= 0; j--) begin
      acc = acc | (gb[j] & pr);
      pr  = pr & pb[j];
    end
    g = acc;
  end

endmodule

// File: rtl/cla_pipe_adder.sv
// Three-stage pipelined carry-lookahead adder/subtractor with valid/ready flow control.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int GROUP = GROUP_DEF
) (
  input  logic          clk,
  input  logic          rst,
  cla_pipe_adder_if.slave bus
);

  localparam int NG = ng_of(WIDTH, GROUP);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] be;
    logic             ce;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
  } s1_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] be;
    logic             ce;
    logic [NG-1:0]    c;
  } s2_t;

  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;

  logic v1, v2, v3;
  logic adv1, adv2, adv3;

  logic [NG-1:0]   grp_p, grp_g;
  logic [GMAX-1:0] pe, ge;
  logic [1:0]      pgv;
  logic            acc, pr;

  logic [NG-1:0]    sgp, sgg;
  logic [WIDTH-1:0] sum;
  logic             pg_d, gg_d, cout_d, ovf_d, pr3;

  logic [WIDTH-1:0] s_q;
  logic             cout_q, ovf_q, zero_q, pg_q, gg_q;

  // Backpressure propagates combinationally from the consumer to in_ready.
  assign adv3 = ~v3 | bus.out_ready;
  assign adv2 = ~v2 | adv3;
  assign adv1 = ~v1 | adv2;

  assign bus.in_ready  = adv1;
  assign bus.out_valid = v3;
  assign bus.s         = s_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.pg        = pg_q;
  assign bus.gg        = gg_q;

  always_comb begin
    s1_d.a  = bus.a;
    s1_d.be = bus.sub ? ~bus.b : bus.b;
    s1_d.ce = bus.sub | bus.cin;
    s1_d.p  = s1_d.a ^ s1_d.be;
    s1_d.g  = s1_d.a & s1_d.be;
  end

  always_comb begin
    grp_p = '0;
    grp_g = '0;
    pe    = '0;
    ge    = '0;
    pgv   = '0;
    acc   = 1'b0;
    pr    = 1'b1;
    for (int i = 0; i < NG; i++) begin
      pe = '0;
      ge = '0;
      pe[GROUP-1:0] = s1_q.p[i*GROUP +: GROUP];
      ge[GROUP-1:0] = s1_q.g[i*GROUP +: GROUP];
      pgv      = group_pg(pe, ge, GROUP);
      grp_p[i] = pgv[1];
      grp_g[i] = pgv[0];
    end
    s2_d.a    = s1_q.a;
    s2_d.be   = s1_q.be;
    s2_d.ce   = s1_q.ce;
    s2_d.c    = '0;
    s2_d.c[0] = s1_q.ce;
    // Every group carry is resolved directly from the group P/G terms and ce.
    for (int i = 1; i < NG; i++) begin
      acc = 1'b0;
      pr  = 1'b1;
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (grp_g[j] & pr);
        pr  = pr & grp_p[j];
      end
      s2_d.c[i] = acc | (pr & s1_q.ce);
    end
  end

  for (genvar i = 0; i < NG; i++) begin : g_grp
    cla_group #(.GROUP(GROUP)) u_grp (
      .a   (s2_q.a[i*GROUP +: GROUP]),
      .b   (s2_q.be[i*GROUP +: GROUP]),
      .cin (s2_q.c[i]),
      .s   (sum[i*GROUP +: GROUP]),
      .p   (sgp[i]),
      .g   (sgg[i])
    );
  end

  always_comb begin
    pg_d = &sgp;
    gg_d = 1'b0;
    pr3  = 1'b1;
    for (int j = NG - 1; j >= 0; j--) begin
      gg_d = gg_d | (sgg[j] & pr3);
      pr3  = pr3 & sgp[j];
    end
    cout_d = gg_d | (pg_d & s2_q.ce);
    // Carry into the MSB is recovered from the MSB sum bit and its operands.
    ovf_d  = (sum[WIDTH-1] ^ s2_q.a[WIDTH-1] ^ s2_q.be[WIDTH-1]) ^ cout_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1     <= 1'b0;
      v2     <= 1'b0;
      v3     <= 1'b0;
      s1_q   <= '0;
      s2_q   <= '0;
      s_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      pg_q   <= 1'b0;
      gg_q   <= 1'b0;
    end else begin
      if (adv1) begin
        v1   <= bus.in_valid;
        s1_q <= s1_d;
      end
      if (adv2) begin
        v2   <= v1;
        s2_q <= s2_d;
      end
      if (adv3) begin
        v3     <= v2;
        s_q    <= sum;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
        zero_q <= ~|sum;
        pg_q   <= pg_d;
        gg_q   <= gg_d;
      end
    end
  end

endmodule
